// File: rtl/local_cmd_scheduler_if.sv
// Handshake and command bundle around local_cmd_scheduler. The master modport is
// the scheduler; the slave modport is the controller/memory environment.
interface local_cmd_scheduler_if #(
  parameter int SAMPLE_ADDR_W = 10,
  parameter int ADDR_VEC_W    = 8,
  parameter int DATAWIDTH     = 16
);
  logic                     start;
  logic [2*DATAWIDTH-1:0]   ld_data;
  logic                     ld_ready;
  logic                     tap_valid;
  logic                     tap_ready;
  logic [SAMPLE_ADDR_W-1:0] tap_delay;
  logic [ADDR_VEC_W-1:0]    tap_dest;
  logic                     pf_valid;
  logic                     pf_ready;
  logic [SAMPLE_ADDR_W-1:0] pf_start;
  logic [SAMPLE_ADDR_W-1:0] pf_stop;
  logic [ADDR_VEC_W-1:0]    pf_dest;
  logic                     WEB;
  logic                     ext_CEB;
  logic                     write_flag;
  logic [SAMPLE_ADDR_W-1:0] ext_sample_address;
  logic [2*DATAWIDTH-1:0]   D;
  logic                     init;
  logic                     from_glob_controller_valid;
  logic [SAMPLE_ADDR_W-1:0] from_glob_controller_delay;
  logic [ADDR_VEC_W-1:0]    from_glob_dest_addr;
  logic                     from_glob_prefetch_valid;
  logic [SAMPLE_ADDR_W-1:0] from_glob_prefetch_start;
  logic [SAMPLE_ADDR_W-1:0] from_glob_prefetch_stop;
  logic [ADDR_VEC_W-1:0]    from_glob_prefetch_dest;
  logic                     busy;
  logic                     err;

  modport master (
    input  start, ld_data, tap_valid, tap_delay, tap_dest,
           pf_valid, pf_start, pf_stop, pf_dest,
    output ld_ready, tap_ready, pf_ready, WEB, ext_CEB, write_flag,
           ext_sample_address, D, init, from_glob_controller_valid,
           from_glob_controller_delay, from_glob_dest_addr,
           from_glob_prefetch_valid, from_glob_prefetch_start,
           from_glob_prefetch_stop, from_glob_prefetch_dest, busy, err
  );

  modport slave (
    output start, ld_data, tap_valid, tap_delay, tap_dest,
           pf_valid, pf_start, pf_stop, pf_dest,
    input  ld_ready, tap_ready, pf_ready, WEB, ext_CEB, write_flag,
           ext_sample_address, D, init, from_glob_controller_valid,
           from_glob_controller_delay, from_glob_dest_addr,
           from_glob_prefetch_valid, from_glob_prefetch_start,
           from_glob_prefetch_stop, from_glob_prefetch_dest, busy, err
  );
endinterface

// File: rtl/local_cmd_scheduler.sv
// Loads the sample memory, programs one tap, then serves tap and prefetch commands.
// Optional macro SCHED_RANGE_CHECK_EN rejects prefetches whose stop precedes start.
module local_cmd_scheduler #(
  parameter int N_SAMPLE      = 1024,
  parameter int SAMPLE_ADDR_W = 10,
  parameter int ADDR_VEC_W    = 8,
  parameter int DATAWIDTH     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                   CLK,
  input logic                   reset,
  local_cmd_scheduler_if.master bus
);
  localparam int CNT_W = SAMPLE_ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(N_SAMPLE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_TAP_WAIT, S_INIT, S_RUN, S_PF_ISSUE, S_PF_GAP
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [SAMPLE_ADDR_W-1:0] tap_delay_q, tap_delay_d;
  logic [ADDR_VEC_W-1:0]    tap_dest_q, tap_dest_d;
  logic [SAMPLE_ADDR_W-1:0] pf_start_q, pf_start_d;
  logic [SAMPLE_ADDR_W-1:0] pf_stop_q, pf_stop_d;
  logic [ADDR_VEC_W-1:0]    pf_dest_q, pf_dest_d;
  logic                     err_q, err_d;
  logic [SAMPLE_ADDR_W-1:0] pf_span;
  logic                     range_bad;

  // A span that wraps to zero means the whole address space.
  assign pf_span = bus.pf_stop - bus.pf_start + SAMPLE_ADDR_W'(1);

`ifdef SCHED_RANGE_CHECK_EN
  assign range_bad = (bus.pf_stop < bus.pf_start);
`else
  assign range_bad = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tap_delay_d = tap_delay_q;
    tap_dest_d  = tap_dest_q;
    pf_start_d  = pf_start_q;
    pf_stop_d   = pf_stop_q;
    pf_dest_d   = pf_dest_q;
    err_d       = 1'b0;

    bus.ld_ready                   = 1'b0;
    bus.tap_ready                  = 1'b0;
    bus.pf_ready                   = 1'b0;
    bus.WEB                        = 1'b1;
    bus.ext_CEB                    = 1'b1;
    bus.write_flag                 = 1'b0;
    bus.ext_sample_address         = '0;
    bus.D                          = '0;
    bus.init                       = 1'b0;
    bus.from_glob_controller_valid = 1'b0;
    bus.from_glob_controller_delay = '0;
    bus.from_glob_dest_addr        = '0;
    bus.from_glob_prefetch_valid   = 1'b0;
    bus.from_glob_prefetch_start   = '0;
    bus.from_glob_prefetch_stop    = '0;
    bus.from_glob_prefetch_dest    = '0;
    bus.busy                       = (state_q != S_IDLE) && (state_q != S_RUN);
    bus.err                        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        bus.WEB                = 1'b0;
        bus.ext_CEB            = 1'b0;
        bus.write_flag         = 1'b1;
        bus.ld_ready           = 1'b1;
        bus.ext_sample_address = cnt_q[SAMPLE_ADDR_W-1:0];
        bus.D                  = bus.ld_data;
        if (cnt_q == LOAD_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_TAP_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_TAP_WAIT: begin
        bus.tap_ready = 1'b1;
        if (bus.tap_valid) begin
          tap_delay_d = bus.tap_delay;
          tap_dest_d  = bus.tap_dest;
          cnt_d       = '0;
          state_d     = S_INIT;
        end
      end
      S_INIT: begin
        bus.init                       = 1'b1;
        bus.from_glob_controller_valid = 1'b1;
        bus.from_glob_controller_delay = tap_delay_q;
        bus.from_glob_dest_addr        = tap_dest_q;
        if (cnt_q == INIT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // A pending tap request masks pf_ready, giving taps priority.
        bus.tap_ready = 1'b1;
        bus.pf_ready  = !bus.tap_valid;
        if (bus.tap_valid) begin
          tap_delay_d = bus.tap_delay;
          tap_dest_d  = bus.tap_dest;
          cnt_d       = '0;
          state_d     = S_INIT;
        end else if (bus.pf_valid) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            pf_start_d = bus.pf_start;
            pf_stop_d  = bus.pf_stop;
            pf_dest_d  = bus.pf_dest;
            len_d      = {pf_span == '0, pf_span};
            state_d    = S_PF_ISSUE;
          end
        end
      end
      S_PF_ISSUE: begin
        bus.from_glob_prefetch_valid = 1'b1;
        bus.from_glob_prefetch_start = pf_start_q;
        bus.from_glob_prefetch_stop  = pf_stop_q;
        bus.from_glob_prefetch_dest  = pf_dest_q;
        if (len_q == CNT_ONE) begin
          state_d = S_PF_GAP;
          len_d   = '0;
        end else begin
          len_d = len_q - CNT_ONE;
        end
      end
      S_PF_GAP: state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      tap_delay_q <= '0;
      tap_dest_q  <= '0;
      pf_start_q  <= '0;
      pf_stop_q   <= '0;
      pf_dest_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tap_delay_q <= tap_delay_d;
      tap_dest_q  <= tap_dest_d;
      pf_start_q  <= pf_start_d;
      pf_stop_q   <= pf_stop_d;
      pf_dest_q   <= pf_dest_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_local_cmd_scheduler.sv
// Directed bench for local_cmd_scheduler: a time-window model checks every cycle,
// and literal checks pin the load, tap, prefetch, collision, range and reset cases.
module tb_local_cmd_scheduler;
  localparam int AW = 10;
  localparam int VW = 8;
  localparam int DW = 16;
  localparam int NS = 1024;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  local_cmd_scheduler_if #(.SAMPLE_ADDR_W(AW), .ADDR_VEC_W(VW), .DATAWIDTH(DW)) bus ();

  local_cmd_scheduler #(
    .N_SAMPLE(NS), .SAMPLE_ADDR_W(AW), .ADDR_VEC_W(VW), .DATAWIDTH(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .CLK(clk),
    .reset(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: activities are windows of absolute cycle numbers opened by accepted
  // requests; outputs follow from which window the current cycle falls in.
  int  n       = 0;
  int  load_c  = -1;
  int  init_c  = -1;
  int  pf_c    = -1;
  int  pf_len  = 0;
  int  err_c   = -1;
  bit  chk_en  = 1'b0;
  logic [AW-1:0] c_delay = '0, c_pfs = '0, c_pfe = '0;
  logic [VW-1:0] c_dest = '0, c_pfd = '0;

  always @(negedge clk) begin : model
    bit idle, in_load, past_settle, in_init, in_pf, in_gap, tap_wait, run;
    bit e_tr, e_pr;
    idle        = (load_c < 0);
    in_load     = !idle && n >= load_c && n < load_c + NS;
    past_settle = !idle && n >= load_c + NS + SC;
    in_init     = init_c >= 0 && n >= init_c && n < init_c + 2;
    in_pf       = pf_c >= 0 && n >= pf_c && n < pf_c + pf_len;
    in_gap      = pf_c >= 0 && n == pf_c + pf_len;
    tap_wait    = past_settle && init_c < 0;
    run         = init_c >= 0 && n >= init_c + 2 && !in_pf && !in_gap;
    e_tr        = tap_wait || run;
    e_pr        = run && !bus.tap_valid;

    if (chk_en) begin
      check("m_WEB", bus.WEB, 64'(!in_load));
      check("m_ext_CEB", bus.ext_CEB, 64'(!in_load));
      check("m_write_flag", bus.write_flag, 64'(in_load));
      check("m_ld_ready", bus.ld_ready, 64'(in_load));
      check("m_addr", bus.ext_sample_address, in_load ? 64'(n - load_c) : 64'd0);
      check("m_D", bus.D, in_load ? 64'(bus.ld_data) : 64'd0);
      check("m_tap_ready", bus.tap_ready, 64'(e_tr));
      check("m_pf_ready", bus.pf_ready, 64'(e_pr));
      check("m_init", bus.init, 64'(in_init));
      check("m_ctrl_valid", bus.from_glob_controller_valid, 64'(in_init));
      check("m_ctrl_delay", bus.from_glob_controller_delay, in_init ? 64'(c_delay) : 64'd0);
      check("m_ctrl_dest", bus.from_glob_dest_addr, in_init ? 64'(c_dest) : 64'd0);
      check("m_pf_valid", bus.from_glob_prefetch_valid, 64'(in_pf));
      check("m_pf_start", bus.from_glob_prefetch_start, in_pf ? 64'(c_pfs) : 64'd0);
      check("m_pf_stop", bus.from_glob_prefetch_stop, in_pf ? 64'(c_pfe) : 64'd0);
      check("m_pf_dest", bus.from_glob_prefetch_dest, in_pf ? 64'(c_pfd) : 64'd0);
      check("m_busy", bus.busy, 64'(!(idle || run)));
      check("m_err", bus.err, 64'(n == err_c));
    end

    if (rst) begin
      load_c = -1; init_c = -1; pf_c = -1; pf_len = 0; err_c = -1;
      c_delay = '0; c_dest = '0; c_pfs = '0; c_pfe = '0; c_pfd = '0;
      chk_en = 1'b1;
    end else begin
      if (idle && bus.start) load_c = n + 1;
      if (e_tr && bus.tap_valid) begin
        init_c  = n + 1;
        c_delay = bus.tap_delay;
        c_dest  = bus.tap_dest;
      end else if (e_pr && bus.pf_valid) begin
`ifdef SCHED_RANGE_CHECK_EN
        if (bus.pf_stop < bus.pf_start) begin
          err_c = n + 1;
        end else
`endif
        begin
          pf_c   = n + 1;
          pf_len = ((int'(bus.pf_stop) - int'(bus.pf_start)) & ((1 << AW) - 1)) + 1;
          c_pfs  = bus.pf_start;
          c_pfe  = bus.pf_stop;
          c_pfd  = bus.pf_dest;
        end
      end
    end
    n++;
  end

  int web_low, settle_n, cnt_a, cnt_b, first_init, first_pf;

  initial begin
    bus.start = 0; bus.ld_data = '0;
    bus.tap_valid = 0; bus.tap_delay = '0; bus.tap_dest = '0;
    bus.pf_valid = 0; bus.pf_start = '0; bus.pf_stop = '0; bus.pf_dest = '0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    check("rst_WEB", bus.WEB, 1);
    check("rst_ext_CEB", bus.ext_CEB, 1);
    check("rst_addr", bus.ext_sample_address, 0);
    check("rst_busy", bus.busy, 0);

    // Load with a counting data stream, then settle into TAP_WAIT.
    tick();
    bus.start = 1;
    tick();
    bus.start = 0;
    web_low = 0; settle_n = 0;
    for (int k = 0; k < 1100; k++) begin
      bus.ld_data = 32'(k);
      @(negedge clk);
      if (!bus.WEB) web_low++;
      if (bus.busy && bus.WEB && !bus.tap_ready) settle_n++;
      tick();
    end
    check("load_web_low_cycles", 64'(web_low), 1024);
    check("settle_cycles", 64'(settle_n), 4);
    @(negedge clk);
    check("tapwait_tap_ready", bus.tap_ready, 1);
    check("tapwait_pf_ready", bus.pf_ready, 0);

    // Tap programming.
    tick();
    bus.tap_valid = 1; bus.tap_delay = 10'h019; bus.tap_dest = 8'h08;
    tick();
    bus.tap_valid = 0; bus.tap_delay = '1; bus.tap_dest = '1;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.init) begin
        cnt_a++;
        check("tap_delay_out", bus.from_glob_controller_delay, 64'h019);
        check("tap_dest_out", bus.from_glob_dest_addr, 64'h08);
      end
      tick();
    end
    check("init_cycles", 64'(cnt_a), 2);
    @(negedge clk);
    check("run_pf_ready", bus.pf_ready, 1);

    // Prefetch 0x36..0x50.
    tick();
    bus.pf_valid = 1; bus.pf_start = 10'h036; bus.pf_stop = 10'h050; bus.pf_dest = 8'h6F;
    tick();
    bus.pf_valid = 0; bus.pf_start = '0; bus.pf_stop = '1; bus.pf_dest = '0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.from_glob_prefetch_valid) begin
        cnt_a++;
        if (cnt_a == 1) check("pf_dest_out", bus.from_glob_prefetch_dest, 64'h6F);
      end else if (bus.busy) begin
        cnt_b++;
      end
      tick();
    end
    check("pf_valid_cycles", 64'(cnt_a), 27);
    check("pf_gap_cycles", 64'(cnt_b), 1);
    @(negedge clk);
    check("pf_after_ready", bus.pf_ready, 1);

    // Tap and prefetch requested together: tap first.
    tick();
    bus.tap_valid = 1; bus.tap_delay = 10'h123; bus.tap_dest = 8'h44;
    bus.pf_valid = 1; bus.pf_start = 10'h010; bus.pf_stop = 10'h012; bus.pf_dest = 8'h55;
    @(negedge clk);
    check("coll_pf_ready", bus.pf_ready, 0);
    check("coll_tap_ready", bus.tap_ready, 1);
    tick();
    bus.tap_valid = 0;
    first_init = -1; first_pf = -1; cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      bit take;
      @(negedge clk);
      if (bus.init && first_init < 0) first_init = i;
      if (bus.from_glob_prefetch_valid) begin
        if (first_pf < 0) first_pf = i;
        cnt_a++;
      end
      take = bus.pf_valid && bus.pf_ready;
      tick();
      if (take) bus.pf_valid = 0;
    end
    check("coll_first_init", 64'(first_init), 0);
    check("coll_first_pf", 64'(first_pf), 3);
    check("coll_pf_cycles", 64'(cnt_a), 3);

    // Tap request raised during a prefetch waits for RUN.
    bus.pf_valid = 1; bus.pf_start = 10'h000; bus.pf_stop = 10'h004; bus.pf_dest = 8'h21;
    tick();
    bus.pf_valid = 0;
    bus.tap_valid = 1; bus.tap_delay = 10'h2AA; bus.tap_dest = 8'h99;
    first_init = -1; cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      bit take;
      @(negedge clk);
      if (bus.init && first_init < 0) first_init = i;
      if (bus.from_glob_prefetch_valid) cnt_a++;
      take = bus.tap_valid && bus.tap_ready;
      tick();
      if (take) bus.tap_valid = 0;
    end
    check("late_tap_pf_cycles", 64'(cnt_a), 5);
    check("late_tap_first_init", 64'(first_init), 7);

    // start is ignored outside IDLE.
    bus.start = 1;
    tick();
    bus.start = 0;
    @(negedge clk);
    check("run_start_ignored", bus.WEB, 1);
    tick();

    // Reversed range 0x50..0x36.
    bus.pf_valid = 1; bus.pf_start = 10'h050; bus.pf_stop = 10'h036; bus.pf_dest = 8'h0F;
    tick();
    bus.pf_valid = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 1010; i++) begin
      @(negedge clk);
      if (bus.from_glob_prefetch_valid) cnt_a++;
      if (bus.err) cnt_b++;
      tick();
    end
`ifdef SCHED_RANGE_CHECK_EN
    check("range_valid_cycles", 64'(cnt_a), 0);
    check("range_err_pulses", 64'(cnt_b), 1);
`else
    check("range_valid_cycles", 64'(cnt_a), 999);
    check("range_err_pulses", 64'(cnt_b), 0);
`endif

    // Reset in the middle of a load, then restart.
    rst = 1;
    tick();
    rst = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    repeat (500) tick();
    rst = 1;
    @(negedge clk);
    check("midload_addr", bus.ext_sample_address, 64'd500);
    check("midload_WEB", bus.WEB, 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("abort_WEB", bus.WEB, 1);
    check("abort_addr", bus.ext_sample_address, 0);
    check("abort_busy", bus.busy, 0);
    tick();
    bus.start = 1;
    tick();
    bus.start = 0;
    @(negedge clk);
    check("restart_WEB", bus.WEB, 0);
    check("restart_addr", bus.ext_sample_address, 0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/local_cmd_scheduler.md
LOCAL_CMD_SCHEDULER -- requirements
Module: local_cmd_scheduler

Interface
REQ-001 SHALL have parameters: N_SAMPLE default 1024, sample-memory depth; SAMPLE_ADDR_W default 10, address width; ADDR_VEC_W default 8, destination vector width; DATAWIDTH default 16, half of the write word; SETTLE_CYCLES default 4, idle cycles between load and init.
REQ-002 SHALL use one clock; reset is synchronous and active-high; the ports are CLK and reset.
REQ-003 Ports (name, direction, width, meaning):
- CLK  in  1  clock.
- reset  in  1  sync active-high reset.
- start  in  1  one-cycle pulse that begins load.
- ld_data  in  2*DATAWIDTH  sample word to write.
- ld_ready  out  1  ld_data consumed this cycle.
- tap_valid/tap_ready  in/out  1/1  tap-config handshake.
- tap_delay  in  SAMPLE_ADDR_W  tap delay.
- tap_dest  in  ADDR_VEC_W  tap destination.
- pf_valid/pf_ready  in/out  1/1  prefetch handshake.
- pf_start, pf_stop  in  SAMPLE_ADDR_W  prefetch range.
- pf_dest  in  ADDR_VEC_W  prefetch destination.
- WEB, ext_CEB, write_flag  out  1  memory write strobes; WEB and ext_CEB are active-low.
- ext_sample_address  out  SAMPLE_ADDR_W  write address.
- D  out  2*DATAWIDTH  write data.
- init, from_glob_controller_valid  out  1  tap programming strobes.
- from_glob_controller_delay  out  SAMPLE_ADDR_W.
- from_glob_dest_addr  out  ADDR_VEC_W.
- from_glob_prefetch_valid  out  1.
- from_glob_prefetch_start, from_glob_prefetch_stop  out  SAMPLE_ADDR_W.
- from_glob_prefetch_dest  out  ADDR_VEC_W.
- busy  out  1  state is not IDLE and not RUN.
- err  out  1  one-cycle rejected-request pulse.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, SETTLE, TAP_WAIT, INIT, RUN, PF_ISSUE, PF_GAP.
REQ-005 IDLE SHALL go to LOAD on start; start is ignored in every other state.
REQ-006 In LOAD the block SHALL hold WEB=0, ext_CEB=0, write_flag=1 and ld_ready=1 for exactly N_SAMPLE cycles, with ext_sample_address stepping 0..N_SAMPLE-1.
REQ-007 D SHALL equal ld_data combinationally in LOAD and be 0 otherwise.
REQ-008 After the last LOAD cycle the block SHALL enter SETTLE with WEB=1, ext_CEB=1, write_flag=0, and hold SETTLE for SETTLE_CYCLES cycles.
REQ-009 SETTLE SHALL go to TAP_WAIT; tap_ready=1 only in TAP_WAIT and in RUN.
REQ-010 When tap_valid and tap_ready are both high, the block SHALL capture tap_delay/tap_dest and enter INIT on the next cycle.
REQ-011 INIT SHALL drive init=1 and from_glob_controller_valid=1 with the captured delay/dest for exactly 2 cycles, then enter RUN.
REQ-012 pf_ready SHALL be 1 only in RUN when tap_valid=0; a tap request therefore has priority over a prefetch when both are valid.
REQ-013 An accepted prefetch SHALL be captured and enter PF_ISSUE, holding from_glob_prefetch_valid=1 with the captured start/stop/dest for L = pf_stop - pf_start + 1 cycles.
REQ-014 PF_ISSUE SHALL be followed by exactly 1 cycle of PF_GAP with valid=0, then RUN.
REQ-015 A tap request arriving during PF_ISSUE or PF_GAP SHALL wait and be served in RUN; the in-flight prefetch is never truncated.
REQ-016 When no valid is asserted, all command data outputs SHALL be 0 and never high-impedance.
REQ-017 The length counter SHALL be SAMPLE_ADDR_W+1 bits wide; pf_start==pf_stop gives L=1.

Reset
REQ-018 While reset is high at a CLK edge, the block SHALL:
- enter IDLE;
- drive WEB=1, ext_CEB=1, and all other outputs 0;
- clear captured registers and counters.
REQ-019 Reset asserted mid-LOAD or mid-PF_ISSUE SHALL abort on that edge, and a new start is required.

Configuration
REQ-020 Macro SCHED_RANGE_CHECK_EN:
- Defined: a prefetch with pf_stop<pf_start is accepted (pf_ready handshake completes) but not issued. err pulses 1 cycle and the state stays RUN.
- Undefined: no check is made, and L = (pf_stop - pf_start + 1) mod 2^SAMPLE_ADDR_W, with 0 treated as 2^SAMPLE_ADDR_W.

Verification
REQ-021 Load: pulse start with ld_data counting from 0 -> WEB=0 for exactly 1024 cycles, address 0..1023, D mirrors ld_data, then 4 SETTLE cycles.
REQ-022 Tap: tap_delay=0x019, tap_dest=0x08 in TAP_WAIT -> init and controller_valid high for 2 cycles carrying 0x019/0x08, then RUN with pf_ready=1.
REQ-023 Prefetch: start=0x36, stop=0x50, dest=0x6F -> prefetch_valid high for 27 cycles, 1 gap cycle, then pf_ready=1.
REQ-024 Collision: tap_valid and pf_valid rise together in RUN -> tap served first (2-cycle INIT), prefetch issued afterwards.
REQ-025 Range: start=0x50, stop=0x36 -> with SCHED_RANGE_CHECK_EN defined, err pulses and no valid is issued; without it, valid is held 999 cycles.
REQ-026 Reset: assert reset at LOAD cycle 500 -> next edge IDLE with WEB=1 and address 0; a second start restarts the load at address 0.
